// File: rtl/bank_rf_pkg.sv
// Shared types and address helpers for the banked multi-port register file.
package bank_rf_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rf_state_e;

  // Bank index: the low bw address bits.
  function automatic int unsigned bank_of(input int unsigned addr, input int unsigned bw);
    return addr & ((32'd1 << bw) - 32'd1);
  endfunction

  // Row inside a bank: the address with the bank bits stripped off.
  function automatic int unsigned row_of(input int unsigned addr, input int unsigned bw);
    return addr >> bw;
  endfunction

endpackage

// File: rtl/bank_rf_bank.sv
// Single register-file bank: one data write port, one clear port, NR async reads.
module bank_rf_bank #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 16,
  parameter int NR    = 4,
  parameter int RW    = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [RW-1:0]            wrow,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     clr,
  input  logic [RW-1:0]            crow,
  input  logic [NR-1:0][RW-1:0]    rrow,
  output logic [NR-1:0][WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];

  // Storage update; the clear sweep owns the bank while it runs.
  always_ff @(posedge clk) begin
    if (clr) mem[crow] <= '0;
    else if (we) mem[wrow] <= wdata;
  end

  // Asynchronous read ports.
  always_comb begin
    for (int p = 0; p < NR; p++) rdata[p] = mem[rrow[p]];
  end

endmodule

// File: rtl/bank_mpregfile_nrnw.sv
// Banked NR-read / NW-write register file with same-bank conflict skid buffer.
module bank_mpregfile_nrnw
  import bank_rf_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int NR          = 4,
  parameter int NW          = 2,
  parameter int RESET_CLEAR = 1,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NR-1:0][AW-1:0]    ra_i,
  output logic [NR-1:0][WIDTH-1:0] rd_o,
  input  logic [NW-1:0][AW-1:0]    wa_i,
  input  logic [NW-1:0][WIDTH-1:0] wd_i,
  input  logic [NW-1:0]            we_i,
  output logic                     ready_o,
  output logic                     init_done_o,
  output logic                     conflict_o
);

  localparam int unsigned BW = $clog2(NW);
  localparam int ROWS        = DEPTH / NW;
  localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW          = (NW > 1) ? $clog2(NW) : 1;
  localparam int NS          = (NW > 1) ? NW - 1 : 1;

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    src;
  } skid_t;

  rf_state_e state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  skid_t skid_q [NS];
  skid_t skid_d [NS];
  logic [NW-1:0] wv, wwin, wcap;
  logic [NS-1:0] skid_ret;
  logic skid_empty_d;

  logic [NW-1:0] bwe;
  logic [RW-1:0] bwrow [NW];
  logic [WIDTH-1:0] bwdata [NW];
  logic [NR-1:0][RW-1:0] rrow;
  logic [NR-1:0][WIDTH-1:0] brd [NW];
  logic clr;

  // Classify incoming writes: valid, bank winner (lowest index) or skid capture.
  always_comb begin
    wv   = '0;
    wwin = '0;
    wcap = '0;
    for (int k = 0; k < NW; k++)
      wv[k] = we_i[k] && (state_q == RUN) && !((ZERO_REG != 0) && (wa_i[k] == '0));
    for (int k = 0; k < NW; k++) begin
      wwin[k] = wv[k];
      for (int j = 0; j < k; j++)
        if (wv[j] && (bank_of(32'(wa_i[j]), BW) == bank_of(32'(wa_i[k]), BW))) wwin[k] = 1'b0;
      wcap[k] = wv[k] && !wwin[k];
    end
  end

  // Per bank, the buffered entry with the oldest source index retires in DRAIN.
  always_comb begin
    skid_ret = '0;
    for (int s = 0; s < NS; s++) begin
      skid_ret[s] = (state_q == DRAIN) && skid_q[s].valid;
      for (int t = 0; t < NS; t++)
        if ((t != s) && skid_q[t].valid && (skid_q[t].src < skid_q[s].src) &&
            (bank_of(32'(skid_q[t].addr), BW) == bank_of(32'(skid_q[s].addr), BW)))
          skid_ret[s] = 1'b0;
    end
  end

  // Skid buffer next state: fill in port order on a conflict, drop retired entries.
  always_comb begin
    int n;
    n = 0;
    skid_empty_d = 1'b1;
    for (int s = 0; s < NS; s++) begin
      skid_d[s] = skid_q[s];
      if (state_q == RUN) begin
        skid_d[s] = '0;
        n = 0;
        for (int k = 0; k < NW; k++) begin
          if (wcap[k]) begin
            if (n == s) skid_d[s] = '{valid: 1'b1, addr: wa_i[k], data: wd_i[k], src: SW'(k)};
            n = n + 1;
          end
        end
      end else if (skid_ret[s]) begin
        skid_d[s].valid = 1'b0;
      end
      if (skid_d[s].valid) skid_empty_d = 1'b0;
    end
  end

  // Skid buffer register; reset throws away any pending writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) skid_q[s] <= '0;
    end else begin
      for (int s = 0; s < NS; s++) skid_q[s] <= skid_d[s];
    end
  end

  // FSM state and clear-row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state and status outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_o     = 1'b0;
    init_done_o = 1'b0;
    conflict_o  = |wcap;
    case (state_q)
      INIT: begin
        if (RESET_CLEAR != 0) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RW'(ROWS - 1)) state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        ready_o     = 1'b1;
        init_done_o = 1'b1;
        if (|wcap) state_d = DRAIN;
      end
      DRAIN: begin
        init_done_o = 1'b1;
        if (skid_empty_d) state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  // Bank write-port steering: bank winners in RUN, retiring skid entries in DRAIN.
  always_comb begin
    for (int b = 0; b < NW; b++) begin
      bwe[b]    = 1'b0;
      bwrow[b]  = '0;
      bwdata[b] = '0;
      for (int k = 0; k < NW; k++) begin
        if (wwin[k] && (bank_of(32'(wa_i[k]), BW) == b)) begin
          bwe[b]    = 1'b1;
          bwrow[b]  = RW'(row_of(32'(wa_i[k]), BW));
          bwdata[b] = wd_i[k];
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (skid_ret[s] && (bank_of(32'(skid_q[s].addr), BW) == b)) begin
          bwe[b]    = 1'b1;
          bwrow[b]  = RW'(row_of(32'(skid_q[s].addr), BW));
          bwdata[b] = skid_q[s].data;
        end
      end
    end
  end

  assign clr = (state_q == INIT) && (RESET_CLEAR != 0);

  // Row part of every read address, shared by all banks.
  always_comb begin
    for (int p = 0; p < NR; p++) rrow[p] = RW'(row_of(32'(ra_i[p]), BW));
  end

  for (genvar b = 0; b < NW; b++) begin : g_bank
    bank_rf_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .NR(NR), .RW(RW)) u_bank (
      .clk   (clk),
      .we    (bwe[b]),
      .wrow  (bwrow[b]),
      .wdata (bwdata[b]),
      .clr   (clr),
      .crow  (cnt_q),
      .rrow  (rrow),
      .rdata (brd[b])
    );
  end

  // Read muxes: bank select, then youngest pending write, then zero/INIT overrides.
  always_comb begin
    for (int p = 0; p < NR; p++) begin
      rd_o[p] = '0;
      for (int b = 0; b < NW; b++)
        if (bank_of(32'(ra_i[p]), BW) == b) rd_o[p] = brd[b][p];
      if (BYPASS != 0)
        for (int s = 0; s < NS; s++)
          if (skid_q[s].valid && (skid_q[s].addr == ra_i[p])) rd_o[p] = skid_q[s].data;
      if ((ZERO_REG != 0) && (ra_i[p] == '0)) rd_o[p] = '0;
      if (state_q == INIT) rd_o[p] = '0;
    end
  end

endmodule

// File: tb/tb_bank_mpregfile_nrnw.sv
// Self-checking bench for bank_mpregfile_nrnw at default parameters.
module tb_bank_mpregfile_nrnw;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0][AW-1:0] ra;
  logic [NR-1:0][W-1:0]  rd;
  logic [NW-1:0][AW-1:0] wa;
  logic [NW-1:0][W-1:0]  wd;
  logic [NW-1:0]         we;
  logic ready, init_done, conflict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bank_mpregfile_nrnw dut (
    .clk         (clk),
    .rst         (rst),
    .ra_i        (ra),
    .rd_o        (rd),
    .wa_i        (wa),
    .wd_i        (wd),
    .we_i        (we),
    .ready_o     (ready),
    .init_done_o (init_done),
    .conflict_o  (conflict)
  );

  // Reference model: committed contents plus a program-ordered list of pending writes.
  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } pw_t;
  logic [W-1:0] mmem [D];
  pw_t pend[$];

  task automatic m_reset();
    for (int i = 0; i < D; i++) mmem[i] = '0;
    pend.delete();
  endtask

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = mmem[a];
    foreach (pend[i]) if (pend[i].a == a) v = pend[i].d;
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic bit m_conflict();
    int n [NW];
    if (pend.size() != 0) return 1'b0;
    for (int b = 0; b < NW; b++) n[b] = 0;
    for (int k = 0; k < NW; k++)
      if (we[k] && wa[k] != 0) n[int'(wa[k]) % NW]++;
    for (int b = 0; b < NW; b++) if (n[b] > 1) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge: accept writes when nothing is pending, otherwise retire one per bank.
  task automatic m_edge();
    bit seen [NW];
    pw_t keep[$];
    for (int b = 0; b < NW; b++) seen[b] = 1'b0;
    if (pend.size() == 0) begin
      for (int k = 0; k < NW; k++) begin
        if (we[k] && wa[k] != 0) begin
          int b;
          b = int'(wa[k]) % NW;
          if (!seen[b]) begin
            mmem[wa[k]] = wd[k];
            seen[b] = 1'b1;
          end else begin
            pend.push_back('{wa[k], wd[k]});
          end
        end
      end
    end else begin
      foreach (pend[i]) begin
        int b;
        b = int'(pend[i].a) % NW;
        if (!seen[b]) begin
          mmem[pend[i].a] = pend[i].d;
          seen[b] = 1'b1;
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge right after rst falls; expects the 16-cycle clear sweep.
  task automatic init_sweep();
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      for (int p = 0; p < NR; p++) ra[p] = AW'($urandom_range(0, D - 1));
      #1;
      if (i < 16) begin
        check($sformatf("init_ready_c%0d", i), W'(ready), 0);
        check($sformatf("init_done_c%0d", i), W'(init_done), 0);
        for (int p = 0; p < NR; p++) check($sformatf("init_rd%0d_c%0d", p, i), rd[p], 0);
      end else begin
        check("ready_rise", W'(ready), 1);
        check("done_rise", W'(init_done), 1);
      end
    end
  endtask

  task automatic readback_zero();
    we = '0;
    for (int c = 0; c < D / NR; c++) begin
      for (int p = 0; p < NR; p++) ra[p] = AW'(c * NR + p);
      #1;
      for (int p = 0; p < NR; p++) check($sformatf("clear_addr%0d", c * NR + p), rd[p], 0);
      @(negedge clk);
    end
  endtask

  // Directed vector table: inputs for one cycle and the outputs required before its edge.
  typedef struct {
    logic [NW-1:0]   we;
    logic [AW-1:0]   wa0, wa1;
    logic [W-1:0]    wd0, wd1;
    logic [AW-1:0]   ra  [NR];
    logic            er, ec;
    logic [W-1:0]    erd [NR];
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input logic [1:0] wev, input int a0, input int d0, input int a1,
                         input int d1, input int r0, input int r1, input int r2, input int r3,
                         input bit er, input bit ec, input int e0, input int e1, input int e2,
                         input int e3);
    vec_t v;
    v.we = wev;  v.wa0 = AW'(a0); v.wd0 = W'(d0); v.wa1 = AW'(a1); v.wd1 = W'(d1);
    v.ra[0] = AW'(r0); v.ra[1] = AW'(r1); v.ra[2] = AW'(r2); v.ra[3] = AW'(r3);
    v.er = er; v.ec = ec;
    v.erd[0] = W'(e0); v.erd[1] = W'(e1); v.erd[2] = W'(e2); v.erd[3] = W'(e3);
    tbl.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0;
    @(negedge clk);
    #1;
    check("rst_ready", W'(ready), 0);
    check("rst_done", W'(init_done), 0);
    check("rst_conflict", W'(conflict), 0);
    check("rst_rd0", rd[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    init_sweep();
    @(negedge clk);
    readback_zero();

    //      we     a0 d0    a1 d1    ra0 ra1 ra2 ra3  rdy cnf  e0    e1    e2    e3
    add_vec(2'b11, 5, 'hA5, 6, 'h5A, 5,  6,  0,  1,   1, 0,   0,    0,    0,    0);
    add_vec(2'b00, 0, 0,    0, 0,    5,  6,  3,  7,   1, 0,   'hA5, 'h5A, 0,    0);
    add_vec(2'b11, 3, 'h11, 7, 'h22, 3,  7,  5,  6,   1, 1,   0,    0,    'hA5, 'h5A);
    add_vec(2'b00, 0, 0,    0, 0,    3,  7,  5,  6,   0, 0,   'h11, 'h22, 'hA5, 'h5A);
    add_vec(2'b00, 0, 0,    0, 0,    3,  7,  0,  9,   1, 0,   'h11, 'h22, 0,    0);
    add_vec(2'b11, 9, 'h1,  9, 'h2,  9,  3,  7,  5,   1, 1,   0,    'h11, 'h22, 'hA5);
    add_vec(2'b11, 10, 'h33, 12, 'h44, 9, 10, 12, 0,  0, 0,   'h2,  0,    0,    0);
    add_vec(2'b00, 0, 0,    0, 0,    9,  10, 12, 3,   1, 0,   'h2,  0,    0,    'h11);
    add_vec(2'b11, 0, 'hFF, 2, 'h77, 0,  2,  9,  10,  1, 0,   0,    0,    'h2,  0);
    add_vec(2'b00, 0, 0,    0, 0,    0,  2,  9,  12,  1, 0,   0,    'h77, 'h2,  0);

    foreach (tbl[i]) begin
      we = tbl[i].we;
      wa[0] = tbl[i].wa0; wd[0] = tbl[i].wd0;
      wa[1] = tbl[i].wa1; wd[1] = tbl[i].wd1;
      for (int p = 0; p < NR; p++) ra[p] = tbl[i].ra[p];
      #1;
      check($sformatf("v%0d_ready", i), W'(ready), W'(tbl[i].er));
      check($sformatf("v%0d_conflict", i), W'(conflict), W'(tbl[i].ec));
      for (int p = 0; p < NR; p++) check($sformatf("v%0d_rd%0d", i, p), rd[p], tbl[i].erd[p]);
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end

    // Randomized traffic, addresses mostly confined to a small window for conflicts and hits.
    for (int c = 0; c < 400; c++) begin
      we = NW'($urandom_range(0, 3));
      for (int k = 0; k < NW; k++) begin
        wa[k] = AW'((c % 5 == 0) ? $urandom_range(0, D - 1) : $urandom_range(0, 7));
        wd[k] = $urandom;
      end
      for (int p = 0; p < NR; p++)
        ra[p] = AW'((c % 4 == 0) ? $urandom_range(0, D - 1) : $urandom_range(0, 7));
      #1;
      check($sformatf("r%0d_ready", c), W'(ready), W'(pend.size() == 0));
      check($sformatf("r%0d_conflict", c), W'(conflict), W'(m_conflict()));
      for (int p = 0; p < NR; p++) check($sformatf("r%0d_rd%0d", c, p), rd[p], m_read(ra[p]));
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end

    // Reset in the middle of a drain.
    we = '0;
    repeat (2) begin
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end
    we = 2'b11; wa[0] = 5'd1; wd[0] = 32'hAB; wa[1] = 5'd13; wd[1] = 32'hCD;
    ra[0] = 5'd13;
    #1;
    check("mid_conflict", W'(conflict), 1);
    @(posedge clk);
    @(negedge clk);
    we = '0;
    #1;
    check("mid_drain_ready", W'(ready), 0);
    check("mid_drain_bypass", rd[0], 32'hCD);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", W'(ready), 0);
    check("mid_rst_rd", rd[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    init_sweep();
    @(negedge clk);
    readback_zero();
    #1;
    check("post_rst_ready", W'(ready), 1);
    check("post_rst_done", W'(init_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
